// File: rtl/wb_regfile_pkg.sv
// Shared processor constants used by the pipeline buffers and the register
// file: data width, register address width and the resulting register count.
package wb_regfile_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

endpackage

// File: rtl/wb_regfile_scoreboard.sv
// reg_scoreboard: one busy bit per architectural register, tracking
// destinations that have been issued but not yet written back.
//   clk, rst             : clock, synchronous active-high reset
//   wb_en, write_add     : write-back clears busy[write_add]
//   read_add1/2, use1/2  : decode-stage sources and their consumption flags
//   issue_en, issue_add  : request to mark issue_add busy (dropped on stall)
//   stall                : hazard stall to fetch/decode
module reg_scoreboard #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] write_add,
    input  logic [ADDR_W-1:0] read_add1,
    input  logic [ADDR_W-1:0] read_add2,
    input  logic              use1,
    input  logic              use2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_add,
    output logic              stall
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             eff_busy1;
    logic             eff_busy2;
    logic             accept;

    // A write-back landing this cycle resolves the hazard for that source,
    // since its data is forwarded through the bypass.
    always_comb begin
        eff_busy1 = busy[read_add1] & ~(wb_en && (write_add == read_add1));
        eff_busy2 = busy[read_add2] & ~(wb_en && (write_add == read_add2));
        stall     = ~rst & ((use1 & eff_busy1) | (use2 & eff_busy2));
        accept    = issue_en & ~stall;
    end

    // Clear before set so a same-register issue and write-back leaves busy set.
    always_comb begin
        busy_next = busy;
        if (wb_en) begin
            busy_next[write_add] = 1'b0;
        end
        if (accept) begin
            busy_next[issue_add] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: register file with same-cycle write-back bypass and a busy-bit
// scoreboard that stalls decode on read-after-issue hazards.
//   clk, rst                 : clock, synchronous active-high reset
//   wb_en, write_add_in,
//   write_data_in            : write-back port from the memory/write-back buffer
//   read_add1/2, use1/2      : decode source addresses and consumption flags
//   issue_en, issue_add      : destination being issued (marked pending)
//   read_data1/2             : combinational source operands
//   stall                    : hazard stall to fetch/decode
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = wb_regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = wb_regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] write_add_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [ADDR_W-1:0] read_add1,
    input  logic [ADDR_W-1:0] read_add2,
    input  logic              use1,
    input  logic              use2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_add,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              stall
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wb_en) begin
            regs[write_add_in] <= write_data_in;
        end
    end

    // While rst is high the array reads as zero, but a concurrent write-back
    // is still forwarded so the bypass path never depends on reset timing.
    always_comb begin
        read_data1 = rst ? '0 : regs[read_add1];
        read_data2 = rst ? '0 : regs[read_add2];
        if (wb_en && (write_add_in == read_add1)) begin
            read_data1 = write_data_in;
        end
        if (wb_en && (write_add_in == read_add2)) begin
            read_data2 = write_data_in;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .write_add (write_add_in),
        .read_add1 (read_add1),
        .read_add2 (read_add2),
        .use1      (use1),
        .use2      (use2),
        .issue_en  (issue_en),
        .issue_add (issue_add),
        .stall     (stall)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: a directed vector table with hand-derived
// expectations, followed by randomized cycles checked against a behavioural
// model (plain arrays of register values and pending flags).
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [2:0]  write_add_in;
    logic [15:0] write_data_in;
    logic [2:0]  read_add1;
    logic [2:0]  read_add2;
    logic        use1;
    logic        use2;
    logic        issue_en;
    logic [2:0]  issue_add;
    logic [15:0] read_data1;
    logic [15:0] read_data2;
    logic        stall;

    always #5 clk = ~clk;

    wb_regfile #(
        .DATA_W (16),
        .ADDR_W (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_en         (wb_en),
        .write_add_in  (write_add_in),
        .write_data_in (write_data_in),
        .read_add1     (read_add1),
        .read_add2     (read_add2),
        .use1          (use1),
        .use2          (use2),
        .issue_en      (issue_en),
        .issue_add     (issue_add),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .stall         (stall)
    );

    typedef struct {
        logic        rst;
        logic        wb;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic        u1;
        logic        u2;
        logic        ie;
        logic [2:0]  ia;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        es;
    } vec_t;

    localparam int unsigned NVEC = 22;
    vec_t tbl [NVEC];

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic [15:0] m_regs [8];
    logic        m_busy [8];

    function automatic vec_t mk(input int r, input int wb, input int wa, input int wd,
                                input int ra1, input int ra2, input int u1, input int u2,
                                input int ie, input int ia,
                                input int e1, input int e2, input int es);
        vec_t v;
        v.rst = r[0];      v.wb = wb[0];      v.wa = wa[2:0];    v.wd = wd[15:0];
        v.ra1 = ra1[2:0];  v.ra2 = ra2[2:0];  v.u1 = u1[0];      v.u2 = u2[0];
        v.ie = ie[0];      v.ia = ia[2:0];
        v.e1 = e1[15:0];   v.e2 = e2[15:0];   v.es = es[0];
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;  wb_en = v.wb;  write_add_in = v.wa;  write_data_in = v.wd;
        read_add1 = v.ra1;  read_add2 = v.ra2;  use1 = v.u1;  use2 = v.u2;
        issue_en = v.ie;  issue_add = v.ia;
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] ra);
        if (wb_en && write_add_in == ra) return write_data_in;
        if (rst) return 16'h0000;
        return m_regs[ra];
    endfunction

    function automatic logic model_stall();
        logic h1;
        logic h2;
        h1 = use1 && m_busy[read_add1] && !(wb_en && write_add_in == read_add1);
        h2 = use2 && m_busy[read_add2] && !(wb_en && write_add_in == read_add2);
        return !rst && (h1 || h2);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic stl;
        stl = model_stall();
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i] = 16'h0000;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wb_en) begin
                m_regs[write_add_in] = write_data_in;
                m_busy[write_add_in] = 1'b0;
            end
            if (issue_en && !stl) m_busy[issue_add] = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 16'h0000;
            m_busy[i] = 1'b0;
        end

        //            rst wb wa wd       ra1 ra2 u1 u2 ie ia  e1       e2       es
        tbl[0]  = mk(1, 0, 0, 0,       3, 5, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
        tbl[1]  = mk(0, 0, 0, 0,       3, 5, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
        tbl[2]  = mk(0, 1, 2, 16'hBEEF, 2, 0, 0, 0, 0, 0, 16'hBEEF, 16'h0000, 0);
        tbl[3]  = mk(0, 0, 0, 0,       2, 2, 0, 0, 0, 0, 16'hBEEF, 16'hBEEF, 0);
        tbl[4]  = mk(0, 0, 0, 0,       2, 0, 0, 0, 1, 4, 16'hBEEF, 16'h0000, 0);
        tbl[5]  = mk(0, 0, 0, 0,       4, 2, 1, 0, 1, 6, 16'h0000, 16'hBEEF, 1);
        tbl[6]  = mk(0, 0, 0, 0,       6, 4, 1, 0, 0, 0, 16'h0000, 16'h0000, 0);
        tbl[7]  = mk(0, 1, 4, 16'h0012, 4, 6, 1, 1, 0, 0, 16'h0012, 16'h0000, 0);
        tbl[8]  = mk(0, 0, 0, 0,       4, 2, 1, 0, 0, 0, 16'h0012, 16'hBEEF, 0);
        tbl[9]  = mk(0, 0, 0, 0,       4, 2, 0, 0, 1, 1, 16'h0012, 16'hBEEF, 0);
        tbl[10] = mk(0, 1, 1, 16'h1111, 1, 2, 1, 0, 1, 1, 16'h1111, 16'hBEEF, 0);
        tbl[11] = mk(0, 0, 0, 0,       1, 4, 1, 0, 0, 0, 16'h1111, 16'h0012, 1);
        tbl[12] = mk(0, 0, 0, 0,       0, 0, 0, 0, 1, 2, 16'h0000, 16'h0000, 0);
        tbl[13] = mk(0, 0, 0, 0,       0, 0, 0, 0, 1, 7, 16'h0000, 16'h0000, 0);
        tbl[14] = mk(0, 0, 0, 0,       2, 7, 1, 1, 0, 0, 16'hBEEF, 16'h0000, 1);
        tbl[15] = mk(1, 0, 0, 0,       2, 7, 1, 1, 1, 3, 16'h0000, 16'h0000, 0);
        tbl[16] = mk(0, 0, 0, 0,       2, 7, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
        tbl[17] = mk(0, 0, 0, 0,       1, 4, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
        tbl[18] = mk(0, 0, 0, 0,       0, 0, 0, 0, 1, 3, 16'h0000, 16'h0000, 0);
        tbl[19] = mk(0, 1, 3, 16'h3333, 3, 5, 1, 1, 1, 5, 16'h3333, 16'h0000, 0);
        tbl[20] = mk(0, 0, 0, 0,       3, 5, 1, 0, 0, 0, 16'h3333, 16'h0000, 0);
        tbl[21] = mk(0, 0, 0, 0,       3, 5, 1, 1, 0, 0, 16'h3333, 16'h0000, 1);

        drive(tbl[0]);
        @(posedge clk);
        #1;

        // Directed table: hand-derived expectations.
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check("vec_read_data1", i, read_data1, tbl[i].e1);
            check("vec_read_data2", i, read_data2, tbl[i].e2);
            check("vec_stall", i, {15'd0, stall}, {15'd0, tbl[i].es});
            model_step();
            @(posedge clk);
            #1;
        end

        // Randomized cycles against the behavioural model.
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v = mk(($urandom_range(0, 39) == 0) ? 1 : 0,
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 16'hFFFF)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   0, 0, 0);
            drive(v);
            @(negedge clk);
            check("rnd_read_data1", n, read_data1, model_read(read_add1));
            check("rnd_read_data2", n, read_data2, model_read(read_add2));
            check("rnd_stall", n, {15'd0, stall}, {15'd0, model_stall()});
            model_step();
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
